// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry-out, signed overflow and a valid flag, one cycle of latency.
// Define ADDER_SATURATE_EN to clamp sum to all-ones on unsigned carry; default build wraps.
module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   full_sum;
    logic [WIDTH-1:0] wrap_sum;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next;
    logic             ovf_next;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        full_sum   = {1'b0, A} + {1'b0, B};
        wrap_sum   = full_sum[WIDTH-1:0];
        carry_next = full_sum[WIDTH];
        // Overflow is judged on the unclamped sum even when saturation is enabled.
        ovf_next   = (A[MSB] == B[MSB]) && (wrap_sum[MSB] != A[MSB]);
`ifdef ADDER_SATURATE_EN
        sum_next   = carry_next ? {WIDTH{1'b1}} : wrap_sum;
`else
        sum_next   = wrap_sum;
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                cout <= carry_next;
                ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases, an exhaustive back-to-back sweep and random traffic
// against an integer-arithmetic reference model.
module tb_adder;

    localparam int W = 4;
    localparam longint MOD = longint'(1) << W;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         in_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;

    int vectors     = 0;
    int checks      = 0;
    int miscompares = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_valid;

    adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .in_valid(in_valid),
        .sum(sum),
        .cout(cout),
        .ovf(ovf),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer sum, unsigned carry as range test, overflow as a signed-range test.
    task automatic model_add(input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, s, sa, sb, ss;
        ua = longint'(a);
        ub = longint'(b);
        s  = ua + ub;
        exp_cout = (s >= MOD);
`ifdef ADDER_SATURATE_EN
        exp_sum = exp_cout ? W'(MOD - 1) : W'(s);
`else
        exp_sum = W'(s % MOD);
`endif
        sa = (ua >= MOD / 2) ? ua - MOD : ua;
        sb = (ub >= MOD / 2) ? ub - MOD : ub;
        ss = sa + sb;
        exp_ovf = (ss > MOD / 2 - 1) || (ss < -(MOD / 2));
    endtask

    // Drive at the falling edge, let the rising edge capture, compare at the next falling edge.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        vectors++;
        if (r) begin
            exp_sum   = '0;
            exp_cout  = 1'b0;
            exp_ovf   = 1'b0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) model_add(a, b);
        end
        @(negedge clk);
        check("sum", 32'(sum), 32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rr, rv;

        // Two reset cycles with live operands: everything stays zero.
        cycle(1'b1, 1'b1, 4'h5, 4'h3);
        check("rst0_sum", 32'(sum), 32'h0);
        check("rst0_valid", 32'(out_valid), 32'h0);
        cycle(1'b1, 1'b1, 4'h5, 4'h3);
        check("rst1_sum", 32'(sum), 32'h0);
        check("rst1_valid", 32'(out_valid), 32'h0);

        cycle(1'b0, 1'b1, 4'h3, 4'h4);
        check("d_3p4_sum", 32'(sum), 32'h7);
        check("d_3p4_valid", 32'(out_valid), 32'h1);

        cycle(1'b0, 1'b1, 4'hF, 4'h1);
`ifdef ADDER_SATURATE_EN
        check("d_Fp1_sum", 32'(sum), 32'hF);
`else
        check("d_Fp1_sum", 32'(sum), 32'h0);
`endif
        check("d_Fp1_cout", 32'(cout), 32'h1);
        check("d_Fp1_ovf", 32'(ovf), 32'h0);

        cycle(1'b0, 1'b1, 4'h7, 4'h1);
        check("d_7p1_sum", 32'(sum), 32'h8);
        check("d_7p1_ovf", 32'(ovf), 32'h1);
        check("d_7p1_cout", 32'(cout), 32'h0);

        cycle(1'b0, 1'b1, 4'h8, 4'h8);
`ifdef ADDER_SATURATE_EN
        check("d_8p8_sum", 32'(sum), 32'hF);
`else
        check("d_8p8_sum", 32'(sum), 32'h0);
`endif
        check("d_8p8_cout", 32'(cout), 32'h1);
        check("d_8p8_ovf", 32'(ovf), 32'h1);

        // Ten back-to-back pairs, each summing to 9.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, W'(i), W'(9 - i));
            check("stream_sum9", 32'(sum), 32'h9);
            check("stream_valid", 32'(out_valid), 32'h1);
        end

        // Hold with in_valid low, including unknown operands.
        cycle(1'b0, 1'b1, 4'h2, 4'h2);
        cycle(1'b0, 1'b0, 4'hA, 4'hA);
        check("hold_sum", 32'(sum), 32'h4);
        check("hold_valid", 32'(out_valid), 32'h0);
        cycle(1'b0, 1'b0, 'x, 'x);
        check("hold_x_sum", 32'(sum), 32'h4);

        // Mid-stream reset discards the pair it coincides with.
        cycle(1'b0, 1'b1, 4'h1, 4'h1);
        cycle(1'b1, 1'b1, 4'h6, 4'h6);
        check("midrst_sum", 32'(sum), 32'h0);
        cycle(1'b0, 1'b0, 4'h6, 4'h6);
        check("midrst_hold", 32'(sum), 32'h0);
        cycle(1'b0, 1'b1, 4'h5, 4'h2);
        check("midrst_first", 32'(sum), 32'h7);

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < MOD; a++)
            for (int b = 0; b < MOD; b++)
                cycle(1'b0, 1'b1, W'(a), W'(b));

        // Random traffic with occasional resets and idle cycles carrying unknown operands.
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 24) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ra = rv ? W'($urandom) : 'x;
            rb = rv ? W'($urandom) : 'x;
            cycle(rr, rv, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
